// File: rtl/flag_cond_unit.sv
// Architectural {N,Z,C,V} flag register, in-flight flag-writer tracking and
// branch condition evaluation with stall-until-final handshake.
module flag_cond_unit #(
    parameter int PEND_W  = 2,
    parameter int TIMEOUT = 64,
    parameter int STALL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flg_issue,
    input  logic              flg_wr_valid,
    input  logic [3:0]        flg_in,
    input  logic              flush,
    input  logic              cond_valid,
    input  logic [3:0]        cond_code,
    output logic              cond_ready,
    output logic              taken_valid,
    output logic              taken,
    output logic [3:0]        flags_out,
    output logic [PEND_W-1:0] pending,
    output logic [1:0]        err
);

    localparam logic [PEND_W-1:0]  PEND_ZERO = '0;
    localparam logic [PEND_W-1:0]  PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0]  PEND_MAX  = '1;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_W-1:0] STALL_TMO = STALL_W'(TIMEOUT);

    logic [3:0]         r_flags;
    logic [PEND_W-1:0]  r_pending;
    logic [STALL_W-1:0] r_stall;
    logic [1:0]         r_err;
    logic               r_taken_valid;
    logic               r_taken;

    logic [PEND_W-1:0]  w_pend_nxt;
    logic               w_cnt_err;
    logic [STALL_W-1:0] w_stall_nxt;
    logic               w_tmo;
    logic               w_cond_ready;
    logic [3:0]         w_eval_flags;
    logic               w_cond_res;

    // Flags are {N,Z,C,V}; codes come in complementary pairs.
    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = f;
        case (code)
            4'h0:    res = z;
            4'h1:    res = !z;
            4'h2:    res = c;
            4'h3:    res = !c;
            4'h4:    res = n;
            4'h5:    res = !n;
            4'h6:    res = v;
            4'h7:    res = !v;
            4'h8:    res = c && !z;
            4'h9:    res = !c || z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = !z && (n == v);
            4'hD:    res = z || (n != v);
            4'hE:    res = 1'b1;
            4'hF:    res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // A request is served when no writer is outstanding, or the last one lands this cycle.
    assign w_cond_ready = cond_valid && !flush &&
                          ((r_pending == PEND_ZERO) ||
                           ((r_pending == PEND_ONE) && flg_wr_valid && !flg_issue));
    assign w_eval_flags = flg_wr_valid ? flg_in : r_flags;
    assign w_cond_res   = cond_eval(cond_code, w_eval_flags);

    // In-flight writer count next state; over/underflow holds and flags an error.
    always_comb begin
        w_pend_nxt = r_pending;
        w_cnt_err  = 1'b0;
        if (flush) begin
            w_pend_nxt = flg_issue ? PEND_ONE : PEND_ZERO;
        end else if (flg_issue && flg_wr_valid) begin
            w_pend_nxt = r_pending;
        end else if (flg_issue) begin
            if (r_pending == PEND_MAX) begin
                w_cnt_err = 1'b1;
            end else begin
                w_pend_nxt = r_pending + PEND_ONE;
            end
        end else if (flg_wr_valid) begin
            if (r_pending == PEND_ZERO) begin
                w_cnt_err = 1'b1;
            end else begin
                w_pend_nxt = r_pending - PEND_ONE;
            end
        end else begin
            w_pend_nxt = r_pending;
        end
    end

    // Saturating count of consecutive unserved request cycles.
    always_comb begin
        w_stall_nxt = '0;
        if (cond_valid && !w_cond_ready && !flush) begin
            if (r_stall == STALL_MAX) begin
                w_stall_nxt = r_stall;
            end else begin
                w_stall_nxt = r_stall + STALL_W'(1);
            end
        end else begin
            w_stall_nxt = '0;
        end
        w_tmo = (w_stall_nxt >= STALL_TMO);
    end

    // State and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags       <= 4'b0000;
            r_pending     <= '0;
            r_stall       <= '0;
            r_err         <= 2'b00;
            r_taken_valid <= 1'b0;
            r_taken       <= 1'b0;
        end else begin
            if (flg_wr_valid) begin
                r_flags <= flg_in;
            end
            r_pending     <= w_pend_nxt;
            r_stall       <= w_stall_nxt;
            r_err         <= r_err | {w_tmo, w_cnt_err};
            r_taken_valid <= w_cond_ready;
            r_taken       <= w_cond_ready ? w_cond_res : 1'b0;
        end
    end

    assign cond_ready  = w_cond_ready;
    assign taken_valid = r_taken_valid;
    assign taken       = r_taken;
    assign flags_out   = r_flags;
    assign pending     = r_pending;
    assign err         = r_err;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed plus randomized bench for flag_cond_unit against a behavioural model.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flg_issue, flg_wr_valid, flush, cond_valid;
    logic [3:0] flg_in, cond_code;
    logic       cond_ready, taken_valid, taken;
    logic [3:0] flags_out;
    logic [1:0] pending;
    logic [1:0] err;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    int         m_pend;
    int         m_stall;
    logic [3:0] m_flags;
    logic [1:0] m_err;
    logic       m_tv, m_tk;
    logic       m_hold;

    flag_cond_unit #(.PEND_W(2), .TIMEOUT(64), .STALL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flg_issue(flg_issue), .flg_wr_valid(flg_wr_valid),
        .flg_in(flg_in), .flush(flush), .cond_valid(cond_valid), .cond_code(cond_code),
        .cond_ready(cond_ready), .taken_valid(taken_valid), .taken(taken),
        .flags_out(flags_out), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Table as base condition per pair; odd codes are the complement.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic model_reset();
        m_pend = 0; m_stall = 0; m_flags = 4'b0000; m_err = 2'b00;
        m_tv = 1'b0; m_tk = 1'b0; m_hold = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".taken_valid"}, {7'd0, taken_valid}, {7'd0, m_tv});
        check({tag, ".taken"}, {7'd0, taken}, {7'd0, m_tk});
        check({tag, ".flags"}, {4'd0, flags_out}, {4'd0, m_flags});
        check({tag, ".pending"}, {6'd0, pending}, 8'(m_pend));
        check({tag, ".err"}, {6'd0, err}, {6'd0, m_err});
    endtask

    task automatic step(input string tag, input logic iss, input logic wr, input logic [3:0] fin,
                        input logic fl, input logic cv, input logic [3:0] cc);
        logic rdy;
        int   np;
        @(negedge clk);
        flg_issue = iss; flg_wr_valid = wr; flg_in = fin; flush = fl;
        cond_valid = cv; cond_code = cc;
        #1;
        rdy = cv && !fl && (m_pend == 0 || (m_pend == 1 && wr && !iss));
        check({tag, ".cond_ready"}, {7'd0, cond_ready}, {7'd0, rdy});
        m_tv = rdy;
        m_tk = rdy ? ref_cond(cc, wr ? fin : m_flags) : 1'b0;
        if (wr) m_flags = fin;
        np = m_pend;
        if (fl)              np = iss ? 1 : 0;
        else if (iss && wr)  np = m_pend;
        else if (iss)        begin if (m_pend == 3) m_err[0] = 1'b1; else np = m_pend + 1; end
        else if (wr)         begin if (m_pend == 0) m_err[0] = 1'b1; else np = m_pend - 1; end
        m_pend = np;
        if (cv && !rdy && !fl) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
        else                   m_stall = 0;
        if (m_stall >= 64) m_err[1] = 1'b1;
        m_hold = cv && !rdy;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        flg_issue = 1'b0; flg_wr_valid = 1'b0; flg_in = 4'h0; flush = 1'b0;
        cond_valid = 1'b0; cond_code = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle pipeline: AL accepted immediately.
        step("al", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hE);
        check("al.taken_const", {7'd0, taken}, 8'd1);
        step("idle", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);

        // One writer outstanding, forwarded on its completion.
        step("iss1", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step("stall_eq", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        step("fwd_eq", 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 4'h0);
        check("fwd_eq.flags_const", {4'd0, flags_out}, 8'h04);
        step("idle", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);

        // Two writers: first completion is not enough.
        step("iss2a", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        step("iss2b", 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hA);
        step("wr2a", 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 4'hA);
        step("wr2b", 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 4'hA);
        check("ge.taken_const", {7'd0, taken}, 8'd1);

        // Counter overflow, then flush with a simultaneous issue.
        for (int i = 0; i < 4; i++) step("ovf", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        check("ovf.err_const", {6'd0, err}, 8'h01);
        step("flush_iss", 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
        check("flush_iss.pend_const", {6'd0, pending}, 8'd1);

        // Timeout: 63 stall cycles clean, 64th raises err[1].
        for (int i = 0; i < 63; i++) step("tmo", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        check("tmo63.err1", {7'd0, err[1]}, 8'd0);
        step("tmo64", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        check("tmo64.err_const", {6'd0, err}, 8'h03);

        // Reset in the middle of a stall drops the request.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        @(posedge clk);
        #1;
        check_outputs("midrst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        cond_valid = 1'b0;

        // Sweep every code under two complementary flag patterns.
        for (int p = 0; p < 2; p++) begin
            logic [3:0] pat;
            pat = (p == 0) ? 4'b1010 : 4'b0101;
            step("sweep_wr", 1'b1, 1'b1, pat, 1'b0, 1'b0, 4'h0);
            for (int c = 0; c < 16; c++) step("sweep", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'(c));
        end

        // Randomized traffic obeying the hold-while-stalled rule.
        for (int i = 0; i < 400; i++) begin
            logic       iss, wr, fl, cv;
            logic [3:0] fin, cc;
            iss = ($urandom_range(0, 3) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            fin = 4'($urandom_range(0, 15));
            if (m_hold) begin
                cv = 1'b1;
                cc = cond_code;
            end else begin
                cv = ($urandom_range(0, 1) == 1);
                cc = 4'($urandom_range(0, 15));
            end
            step("rand", iss, wr, fin, fl, cv, cc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
